// File: rtl/z88_mem_pkg.sv
// Shared definitions for the Z88 SRAM arbiter.
// Contents: arbiter state encoding, requester port identifiers, and the SRAM
// byte and word address widths.
package z88_mem_pkg;

    localparam int unsigned BYTE_AW = 19;  // byte address into 512 KiB
    localparam int unsigned WORD_AW = 18;  // 16-bit word address, 256K words

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RECOV
    } state_e;

endpackage

// File: rtl/z88_sram_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a single asynchronous
// 256K x 16 SRAM shared by two byte-wide requesters.
//
// Ports:
//   clk, reset_n            system clock, synchronous active-low reset
//   p0_* / p1_*             requester ports (req level, we, byte address,
//                           write data, read data, one-cycle ack)
//   sram_addr               word address to the SRAM
//   sram_dq_i / sram_dq_o   SRAM data in / data out
//   sram_dq_oe              data bus drive enable for the top-level tristate
//   sram_*_n                active-low SRAM strobes
//
// Every output comes straight from a register. Each access runs
// IDLE -> ACCESS -> RECOV. A read strobes OE for RD_CYCLES cycles. A write
// has one setup cycle, then WR_CYCLES cycles with WE low. RECOV pulses the ack.
module z88_sram_arbiter
    import z88_mem_pkg::*;
#(
    parameter int unsigned RD_CYCLES = 2,
    parameter int unsigned WR_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset_n,

    input  logic               p0_req,
    input  logic               p0_we,
    input  logic [BYTE_AW-1:0] p0_a,
    input  logic [7:0]         p0_di,
    output logic [7:0]         p0_do,
    output logic               p0_ack,

    input  logic               p1_req,
    input  logic               p1_we,
    input  logic [BYTE_AW-1:0] p1_a,
    input  logic [7:0]         p1_di,
    output logic [7:0]         p1_do,
    output logic               p1_ack,

    output logic [WORD_AW-1:0] sram_addr,
    input  logic [15:0]        sram_dq_i,
    output logic [15:0]        sram_dq_o,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int unsigned MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               grant_q, grant_d;
    logic               last_q, last_d;
    logic               we_q, we_d;
    logic [BYTE_AW-1:0] a_q, a_d;
    logic [7:0]         di_q, di_d;
    logic [7:0]         p0_do_q, p0_do_d;
    logic [7:0]         p1_do_q, p1_do_d;
    logic               ce_n_q, ce_n_d;
    logic               oe_n_q, oe_n_d;
    logic               we_n_q, we_n_d;
    logic               ub_n_q, ub_n_d;
    logic               lb_n_q, lb_n_d;
    logic               dq_oe_q, dq_oe_d;
    logic               p0_ack_q, p0_ack_d;
    logic               p1_ack_q, p1_ack_d;

    logic [7:0]         rd_byte;
    logic               in_access;
    logic               in_recov;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        we_d    = we_q;
        a_d     = a_q;
        di_d    = di_q;
        p0_do_d = p0_do_q;
        p1_do_d = p1_do_q;
        rd_byte = a_q[0] ? sram_dq_i[15:8] : sram_dq_i[7:0];

        unique case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    // Under contention, the port that did not win last time is granted.
                    grant_d = (p0_req && p1_req) ? ~last_q : p1_req;
                    last_d  = grant_d;
                    we_d    = grant_d ? p1_we : p0_we;
                    a_d     = grant_d ? p1_a  : p0_a;
                    di_d    = grant_d ? p1_di : p0_di;
                    // A write has one setup cycle plus WR_CYCLES pulse cycles.
                    cnt_d   = we_d ? CW'(WR_CYCLES) : CW'(RD_CYCLES - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RECOV;
                    if (!we_q) begin
                        if (grant_q == PORT_AUX) begin
                            p1_do_d = rd_byte;
                        end else begin
                            p0_do_d = rd_byte;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RECOV: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Output registers are loaded from the state being entered, so the
        // strobes line up with the registered state.
        in_access = (state_d == ACCESS);
        in_recov  = (state_d == RECOV);
        ce_n_d    = ~in_access;
        oe_n_d    = ~(in_access & ~we_d);
        we_n_d    = ~(in_access & we_d & (cnt_d != CW'(WR_CYCLES)));
        lb_n_d    = ~(in_access & ~a_d[0]);
        ub_n_d    = ~(in_access & a_d[0]);
        // Write data is held through RECOV and is never driven during a read.
        dq_oe_d   = we_d & (in_access | in_recov);
        p0_ack_d  = in_recov & (grant_d == PORT_CPU);
        p1_ack_d  = in_recov & (grant_d == PORT_AUX);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            grant_q  <= PORT_CPU;
            last_q   <= PORT_AUX;
            we_q     <= 1'b0;
            a_q      <= '0;
            di_q     <= 8'h00;
            p0_do_q  <= 8'h00;
            p1_do_q  <= 8'h00;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            ub_n_q   <= 1'b1;
            lb_n_q   <= 1'b1;
            dq_oe_q  <= 1'b0;
            p0_ack_q <= 1'b0;
            p1_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            we_q     <= we_d;
            a_q      <= a_d;
            di_q     <= di_d;
            p0_do_q  <= p0_do_d;
            p1_do_q  <= p1_do_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            ub_n_q   <= ub_n_d;
            lb_n_q   <= lb_n_d;
            dq_oe_q  <= dq_oe_d;
            p0_ack_q <= p0_ack_d;
            p1_ack_q <= p1_ack_d;
        end
    end

    assign sram_addr  = a_q[BYTE_AW-1:1];
    assign sram_dq_o  = {di_q, di_q};
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_ub_n  = ub_n_q;
    assign sram_lb_n  = lb_n_q;
    assign p0_do      = p0_do_q;
    assign p1_do      = p1_do_q;
    assign p0_ack     = p0_ack_q;
    assign p1_ack     = p1_ack_q;

endmodule

// File: doc/z88_sram_arbiter.md
Name: z88_sram_arbiter

Overview:
- Shares the board's single asynchronous 16-bit SRAM (256K x 16) between two byte-wide requesters:
  - port 0: Z88 core RAM bus, meaning CPU/blink accesses.
  - port 1: auxiliary master, meaning the ROM/RAM image loader or a debug/DMA engine.
- Sequences every access with a fixed, parameterised timing and generates CE/OE/WE/UB/LB.
- Drives the data bus only during writes.
- Sits between the z88 core and the top-level SRAM pins; the top level only ties the DQ tristate.

Parameters:
- RD_CYCLES, 2: SRAM read strobe length in clk cycles (>=1).
- WR_CYCLES, 2: WE_n low pulse length in clk cycles (>=1).

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- p0_req  in  1  port 0 request; level, held until p0_ack
- p0_we  in  1  port 0 write (1) / read (0)
- p0_a  in  19  port 0 byte address
- p0_di  in  8  port 0 write data
- p0_do  out  8  port 0 read data
- p0_ack  out  1  port 0 one-cycle completion pulse
- p1_req, p1_we, p1_a, p1_di, p1_do, p1_ack: same as port 0, for port 1
- sram_addr  out  18  word address
- sram_dq_i  in  16  SRAM data in
- sram_dq_o  out  16  SRAM data out
- sram_dq_oe  out  1  top level drives DQ when 1, else Z
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active low

Behaviour:
- All outputs are registered. On reset (sync, reset_n=0 at an edge), on the next edge:
  - state=IDLE, all strobes=1, dq_oe=0, acks=0, p0_do=p1_do=0x00, sram_addr=0, last_grant=1 (port 0 wins first contention).
- Reset asserted mid-access aborts it: no ack is issued, and strobes go inactive on that edge.
- FSM states:
  - IDLE: samples requests.
    - Neither pending: stay.
    - One pending: grant it.
    - Both pending: grant the port not in last_grant (round-robin), then update last_grant.
    - On grant: latch we/a/di, load the counter, go to ACCESS.
  - ACCESS, read: lasts RD_CYCLES cycles.
    - ce_n=0, oe_n=0; lane strobe: a[0]=0 -> lb_n=0, a[0]=1 -> ub_n=0.
    - sram_dq_i is captured on the final ACCESS edge. Byte select: a[0]=0 -> dq[7:0], else dq[15:8].
  - ACCESS, write: lasts 1+WR_CYCLES cycles.
    - First cycle is setup: ce_n=0, we_n=1, dq_oe=1, dq_o={di,di}.
    - Remaining WR_CYCLES cycles: we_n=0.
    - oe_n stays 1 throughout.
  - RECOV: one cycle.
    - we_n=1, oe_n=1, ce_n=1.
    - For a write, dq_oe stays 1 this cycle (data hold), then drops in IDLE.
    - Granted port's ack=1 for exactly this cycle. For a read, its p_do is updated and valid in this cycle.
    - Next state is IDLE.
- sram_addr = a[18:1] and stays stable from the first ACCESS cycle through RECOV.
- Latency, counted from a req seen high in IDLE at cycle 0:
  - Read ack at cycle RD_CYCLES+1.
  - Write ack at cycle WR_CYCLES+2.
  - Minimum spacing between grants is RD_CYCLES+2 (read) or WR_CYCLES+3 (write) cycles.
- Requester rules:
  - After ack, a requester must drop req or present a new request.
  - A req still high in the IDLE cycle after RECOV is a new access.
- p_do holds its last read value until the next read completes on that port; writes do not change p_do.
- The ungranted port's ack stays 0. Its request waits and is served no later than the next grant (no starvation).
- If req drops before ack (protocol violation), the access still completes and ack is still pulsed.
- dq_oe is never 1 during a read, including the ACCESS/RECOV boundary.

Decomposition:
- Package z88_mem_pkg:
  - state enum {IDLE, ACCESS, RECOV}.
  - constants PORT_CPU=0, PORT_AUX=1.
  - SRAM address widths (byte 19, word 18).
- Single module; the access counter is inline. No sub-module is warranted.

Test Plan:
- Port 0 read of 0x00001, SRAM model word 0 = 0xA55A, defaults -> lb_n=1, ub_n=0, oe_n low for 2 cycles, p0_ack at cycle 3, p0_do=0xA5, dq_oe=0 throughout.
- Port 1 write 0x3C to 0x7FFFE -> sram_addr=0x3FFFF, lb_n=0, dq_o=0x3C3C, we_n low exactly 2 cycles after one setup cycle, dq_oe high through RECOV, p1_ack at cycle 4, only low byte of model changed.
- Both ports request reads continuously for 6 grants -> grants alternate 0,1,0,1,0,1 (port 0 first after reset); each ack is a single cycle; no overlapping strobes.
- reset_n=0 on the second write-pulse cycle -> next edge we_n=ce_n=1, dq_oe=0, no ack; a read of the same address afterwards completes normally.
- RD_CYCLES=1, WR_CYCLES=1 build, back-to-back port 0 read then write -> read ack at cycle 2, write granted at cycle 3, write ack at cycle 6; p0_do unchanged by the write.
